// File: rtl/dm_bus_arbiter.sv
// dm_bus_arbiter
//   Shares the peripheral data-memory/GPIO bus between two requesters:
//   M0 (CPU data port) and M1 (debug loader / DMA). One transfer at a time,
//   round-robin (RR_EN=1) or fixed priority with M0 winning (RR_EN=0).
//   Addresses outside the decoded regions are rejected without a bus cycle.
//
// Ports
//   clk, rst             system clock; asynchronous active-low reset
//   mN_req/we/addr/      requester N (N=0,1); fields held until mN_ack
//   mN_wdata/mN_op
//   mN_ack, mN_err       one-cycle completion pulse; err=1 means rejected
//   mN_rdata             read data, valid with ack on a read, held otherwise
//   dm_w, dm_r           bus strobes, asserted only for the single ACCESS cycle
//   addr, wdata, dm_op   bus address / write data / op (zero when idle)
//   rdata                bus read data, combinational from the peripheral
module dm_bus_arbiter #(
    parameter bit RR_EN    = 1'b1,
    parameter bit CHK_ADDR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_op,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_op,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        dm_w,
    output logic        dm_r,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic [2:0]  dm_op,
    input  logic [31:0] rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state;
    logic   last;   // requester granted most recently (1 = M1)
    logic   cur;    // requester owning the transfer in flight

    logic        win;
    logic        win_we;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic [2:0]  win_op;
    logic        win_ok;

    // Winner selection; only consulted in IDLE when at least one req is high.
    always_comb begin
        if (m0_req && m1_req)
            win = RR_EN ? ~last : 1'b0;
        else
            win = ~m0_req;
        win_we    = win ? m1_we    : m0_we;
        win_addr  = win ? m1_addr  : m0_addr;
        win_wdata = win ? m1_wdata : m0_wdata;
        win_op    = win ? m1_op    : m0_op;
        win_ok    = !CHK_ADDR
                    || (win_addr[31:16] == 16'hbf80)
                    || (win_addr[31:16] == 16'h8000)
                    || (win_addr[31:16] == 16'h8003);
    end

    // Bus outputs double as the latched transfer registers: they hold the
    // winner's fields only during ACCESS and are zero in every other state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            cur      <= 1'b0;
            dm_w     <= 1'b0;
            dm_r     <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            dm_op    <= '0;
            m0_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= '0;
            m1_ack   <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        cur  <= win;
                        last <= win;
                        if (win_ok) begin
                            dm_w  <= win_we;
                            dm_r  <= ~win_we;
                            addr  <= win_addr;
                            wdata <= win_wdata;
                            dm_op <= win_op;
                            state <= ACCESS;
                        end else begin
                            m0_ack <= ~win;
                            m0_err <= ~win;
                            m1_ack <= win;
                            m1_err <= win;
                            state  <= DONE;
                        end
                    end
                end
                ACCESS: begin
                    if (dm_r) begin
                        if (cur)
                            m1_rdata <= rdata;
                        else
                            m0_rdata <= rdata;
                    end
                    m0_ack <= ~cur;
                    m1_ack <= cur;
                    dm_w   <= 1'b0;
                    dm_r   <= 1'b0;
                    addr   <= '0;
                    wdata  <= '0;
                    dm_op  <= '0;
                    state  <= DONE;
                end
                DONE: begin
                    m0_ack <= 1'b0;
                    m0_err <= 1'b0;
                    m1_ack <= 1'b0;
                    m1_err <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// tb_dm_bus_arbiter
//   Self-checking bench for dm_bus_arbiter. Instance "dut" uses round-robin,
//   instance "dut_fp" fixed priority (shares inputs, its own outputs).
//   A transaction-level model predicts grant order, timing, err and rdata.
module tb_dm_bus_arbiter;

    localparam logic [2:0] OP_WD = 3'd2;
    localparam logic [2:0] OP_RW = 3'd5;
    localparam logic [2:0] OP_RB = 3'd4;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  op;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [2:0]  m0_op, m1_op;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        dm_w, dm_r;
    logic [31:0] addr, wdata;
    logic [2:0]  dm_op;
    logic [31:0] rdata = '0;

    logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic        b_dm_w, b_dm_r;
    logic [31:0] b_addr, b_wdata;
    logic [2:0]  b_dm_op;

    dm_bus_arbiter #(.RR_EN(1'b1), .CHK_ADDR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_op(m0_op),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_op(m1_op),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .dm_w(dm_w), .dm_r(dm_r), .addr(addr), .wdata(wdata), .dm_op(dm_op), .rdata(rdata)
    );

    dm_bus_arbiter #(.RR_EN(1'b0), .CHK_ADDR(1'b1)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_op(m0_op),
        .m0_ack(b_m0_ack), .m0_err(b_m0_err), .m0_rdata(b_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_op(m1_op),
        .m1_ack(b_m1_ack), .m1_err(b_m1_err), .m1_rdata(b_m1_rdata),
        .dm_w(b_dm_w), .dm_r(b_dm_r), .addr(b_addr), .wdata(b_wdata), .dm_op(b_dm_op),
        .rdata(32'h0)
    );

    // Peripheral: writes land on negedge; read data settles by the next posedge.
    logic [31:0] bus_mem [logic [31:0]];
    always @(negedge clk) begin
        if (dm_w) bus_mem[addr] = wdata;
        rdata = bus_mem.exists(addr) ? bus_mem[addr] : ~addr;
    end

    // Reference model state
    logic [31:0] ref_mem [logic [31:0]];
    int          last_m;
    logic [31:0] exp_rdata [2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] op);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.op = op;
        return t;
    endfunction

    function automatic bit legal(input logic [31:0] a);
        return a[31:16] == 16'hbf80 || a[31:16] == 16'h8000 || a[31:16] == 16'h8003;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : ~a;
    endfunction

    task automatic drive(input int p, input bit req, input txn_t t);
        if (p == 0) begin
            m0_req = req; m0_we = t.we; m0_addr = t.addr; m0_wdata = t.wdata; m0_op = t.op;
        end else begin
            m1_req = req; m1_we = t.we; m1_addr = t.addr; m1_wdata = t.wdata; m1_op = t.op;
        end
    endtask

    task automatic model_reset();
        last_m = 1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dm_w"}, {31'b0, dm_w}, 32'd0);
        check({tag, "_dm_r"}, {31'b0, dm_r}, 32'd0);
        check({tag, "_addr"}, addr, 32'd0);
        check({tag, "_wdata"}, wdata, 32'd0);
        check({tag, "_dm_op"}, {29'b0, dm_op}, 32'd0);
        check({tag, "_acks"}, {28'b0, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);
        check({tag, "_m0_rdata"}, m0_rdata, 32'd0);
        check({tag, "_m1_rdata"}, m1_rdata, 32'd0);
        check({tag, "_fp_outs"}, {26'b0, b_dm_w, b_dm_r, b_m0_ack, b_m1_ack, b_m0_err, b_m1_err}, 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("reset");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Issue requests (called at a negedge with the DUT idle) and check every
    // cycle until all requested transfers have completed and the bus is idle.
    task automatic run_xfers(input bit r0, input bit r1, input txn_t t0, input txn_t t1);
        bit   pend [2];
        txn_t t [2];
        bit   busy = 0, lg = 0, strobe, ackn;
        int   w = 0, s = 0, n = 0, next_ok = 1;
        t[0] = t0; t[1] = t1; pend[0] = r0; pend[1] = r1;
        drive(0, r0, t0);
        drive(1, r1, t1);
        while ((pend[0] || pend[1] || busy || n < next_ok - 1) && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!busy && n >= next_ok && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) w = (last_m == 1) ? 0 : 1;
                else w = pend[0] ? 0 : 1;
                busy = 1; s = n; last_m = w; lg = legal(t[w].addr);
            end
            strobe = busy && lg && (n == s);
            ackn   = busy && (n == s + (lg ? 1 : 0));
            check("dm_w", {31'b0, dm_w}, {31'b0, strobe && t[w].we});
            check("dm_r", {31'b0, dm_r}, {31'b0, strobe && !t[w].we});
            check("bus_addr", addr, strobe ? t[w].addr : 32'd0);
            check("bus_wdata", wdata, strobe ? t[w].wdata : 32'd0);
            check("bus_op", {29'b0, dm_op}, strobe ? {29'b0, t[w].op} : 32'd0);
            check("m0_ack", {31'b0, m0_ack}, {31'b0, ackn && w == 0});
            check("m1_ack", {31'b0, m1_ack}, {31'b0, ackn && w == 1});
            if (ackn) begin
                check("err", {31'b0, (w == 0) ? m0_err : m1_err}, {31'b0, !lg});
                if (lg && t[w].we) ref_mem[t[w].addr] = t[w].wdata;
                if (lg && !t[w].we) exp_rdata[w] = ref_read(t[w].addr);
                check("m0_rdata", m0_rdata, exp_rdata[0]);
                check("m1_rdata", m1_rdata, exp_rdata[1]);
                pend[w] = 0;
                drive(w, 1'b0, t[w]);
                busy = 0;
                next_ok = n + 2;
            end
        end
        check("cycle_budget", {31'b0, n < 40}, 32'd1);
    endtask

    function automatic txn_t rand_txn();
        logic [15:0] hi;
        logic [15:0] lo;
        case ($urandom_range(0, 7))
            0:       hi = 16'h1234;
            1:       hi = 16'h8001;
            2, 3:    hi = 16'hbf80;
            4, 5:    hi = 16'h8000;
            default: hi = 16'h8003;
        endcase
        lo = 16'($urandom_range(0, 7) * 4);
        return mk(1'($urandom_range(0, 1)), {hi, lo}, $urandom, 3'($urandom_range(0, 7)));
    endfunction

    txn_t idle_t;
    txn_t ta, tb;
    int   rr_next;

    initial begin
        idle_t = mk(1'b0, 32'd0, 32'd0, 3'd0);
        rst = 1'b0;
        drive(0, 1'b0, idle_t);
        drive(1, 1'b0, idle_t);
        model_reset();
        #12;
        check_reset_outputs("por");
        pulse_reset();

        // Single write, then read back through the other requester
        run_xfers(1, 0, mk(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, OP_WD), idle_t);
        run_xfers(0, 1, idle_t, mk(1'b0, 32'h8000_0010, 32'd0, OP_RW));
        check("t2_m1_rdata", m1_rdata, 32'hDEAD_BEEF);

        // Rejected address: err with ack and no strobe
        run_xfers(0, 1, idle_t, mk(1'b1, 32'h1234_0000, 32'h5555_AAAA, OP_WD));

        // GPIO read with a non-default op
        run_xfers(0, 1, idle_t, mk(1'b1, 32'hbf80_0004, 32'h0000_00A5, OP_WD));
        run_xfers(1, 0, mk(1'b0, 32'hbf80_0004, 32'd0, OP_RB), idle_t);
        check("t5_m0_rdata", m0_rdata, 32'h0000_00A5);

        // Continuous contention from reset: RR alternates, FP serves only M0
        pulse_reset();
        ta = mk(1'b1, 32'h8000_0100, 32'h1111_0000, OP_WD);
        tb = mk(1'b1, 32'h8003_0200, 32'h2222_0000, OP_WD);
        drive(0, 1'b1, ta);
        drive(1, 1'b1, tb);
        rr_next = 0;
        for (int n = 1; n <= 18; n++) begin
            @(posedge clk);
            @(negedge clk);
            check("t3_ack_overlap", {31'b0, m0_ack & m1_ack}, 32'd0);
            if (n % 3 == 2) begin
                check("t3_rr_m0_ack", {31'b0, m0_ack}, {31'b0, rr_next == 0});
                check("t3_rr_m1_ack", {31'b0, m1_ack}, {31'b0, rr_next == 1});
                check("t3_fp_m0_ack", {31'b0, b_m0_ack}, 32'd1);
                rr_next = 1 - rr_next;
            end else begin
                check("t3_rr_quiet", {30'b0, m0_ack, m1_ack}, 32'd0);
                check("t3_fp_quiet", {31'b0, b_m0_ack}, 32'd0);
            end
            check("t3_fp_m1_ack", {31'b0, b_m1_ack}, 32'd0);
        end
        drive(0, 1'b0, ta);
        drive(1, 1'b0, tb);
        ref_mem[ta.addr] = ta.wdata;
        ref_mem[tb.addr] = tb.wdata;
        last_m = (rr_next == 0) ? 1 : 0;

        // Randomized single and contending transfers
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(1, 3);
            run_xfers(sel[0], sel[1], rand_txn(), rand_txn());
        end

        // Reset in the middle of an M1 read; M0 must win the first tie afterwards
        run_xfers(1, 0, mk(1'b1, 32'h8000_0020, 32'hCAFE_0001, OP_WD), idle_t);
        ta = mk(1'b0, 32'h8000_0020, 32'd0, OP_RW);
        tb = mk(1'b0, 32'h8003_0004, 32'd0, OP_RW);
        drive(0, 1'b1, ta);
        drive(1, 1'b1, tb);
        @(posedge clk);
        #2;
        check("t6_access_m1", {31'b0, dm_r}, 32'd1);
        check("t6_access_addr", addr, tb.addr);
        rst = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        run_xfers(1, 1, ta, tb);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
